// File: rtl/data_sram_responder.sv
// Data-SRAM responder: one-cycle-latency word RAM plus a memory-mapped config register file.
// Defining CONFREG_PERF_CNT_EN adds RD_CNT/WR_CNT access counters at offsets 0x20/0x24.
module data_sram_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] CONF_BASE  = 32'hBFAF_0000,
    parameter logic [31:0] CONF_MASK  = 32'hFFFF_0000,
    parameter logic [31:0] SIM_FLAG   = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);
    // Config offsets as word indices (addr[15:2]).
    localparam logic [13:0] OFF_LED     = 14'h0000;
    localparam logic [13:0] OFF_SWITCH  = 14'h0001;
    localparam logic [13:0] OFF_TIMER   = 14'h0002;
    localparam logic [13:0] OFF_NUM     = 14'h0003;
    localparam logic [13:0] OFF_SIMFLAG = 14'h0004;
    localparam logic [13:0] OFF_SCRATCH = 14'h0005;
`ifdef CONFREG_PERF_CNT_EN
    localparam logic [13:0] OFF_RD_CNT  = 14'h0008;
    localparam logic [13:0] OFF_WR_CNT  = 14'h0009;
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic        perf_hit;
`endif

    logic [31:0] mem [2**ADDR_WIDTH];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d, timer_inc;
    logic [31:0] scratch_q, scratch_d;
    logic [15:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;

    logic                  is_conf, wr_req, conf_wr, ram_wr;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [13:0]           woff;
    logic [31:0]           conf_rd;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    assign is_conf = ((data_sram_addr & CONF_MASK) == (CONF_BASE & CONF_MASK));
    assign ram_idx = data_sram_addr[ADDR_WIDTH+1:2];
    assign woff    = data_sram_addr[15:2];
    assign wr_req  = (data_sram_we != 4'b0000);
    assign conf_wr = data_sram_en && wr_req && is_conf;
    assign ram_wr  = data_sram_en && wr_req && !is_conf;

    always_comb begin
        conf_rd = '0;
        case (woff)
            OFF_LED:     conf_rd = {16'h0000, led_q};
            OFF_SWITCH:  conf_rd = {16'h0000, sw_sync_q};
            OFF_TIMER:   conf_rd = timer_q;
            OFF_NUM:     conf_rd = num_q;
            OFF_SIMFLAG: conf_rd = SIM_FLAG;
            OFF_SCRATCH: conf_rd = scratch_q;
`ifdef CONFREG_PERF_CNT_EN
            OFF_RD_CNT:  conf_rd = rd_cnt_q;
            OFF_WR_CNT:  conf_rd = wr_cnt_q;
`endif
            default:     conf_rd = '0;
        endcase
    end

    // Read-first: rdata captures the pre-write word; idle cycles hold the last value.
    always_comb begin
        rdata_d = rdata_q;
        if (data_sram_en) rdata_d = is_conf ? conf_rd : mem[ram_idx];
    end

    // Written TIMER bytes override the incremented value byte by byte.
    always_comb begin
        timer_inc = timer_q + 32'd1;
        led_d     = led_q;
        num_d     = num_q;
        timer_d   = timer_inc;
        scratch_d = scratch_q;
        sw_meta_d = switch_in;
        sw_sync_d = sw_meta_q;
        if (conf_wr) begin
            case (woff)
                OFF_LED: begin
                    if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
                end
                OFF_TIMER:   timer_d   = merge_bytes(timer_inc, data_sram_wdata, data_sram_we);
                OFF_NUM:     num_d     = merge_bytes(num_q, data_sram_wdata, data_sram_we);
                OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_we);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= '0;
            led_q     <= 16'hFFFF;
            num_q     <= '0;
            timer_q   <= '0;
            scratch_q <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

`ifdef CONFREG_PERF_CNT_EN
    // Accesses to the counters themselves are not counted; any write clears.
    always_comb begin
        perf_hit = is_conf && ((woff == OFF_RD_CNT) || (woff == OFF_WR_CNT));
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (data_sram_en && !perf_hit) begin
            if (wr_req) wr_cnt_d = wr_cnt_q + 32'd1;
            else        rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (conf_wr && (woff == OFF_RD_CNT)) rd_cnt_d = '0;
        if (conf_wr && (woff == OFF_WR_CNT)) wr_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end
`endif

    assign data_sram_rdata = rdata_q;
    assign led_out         = led_q;
    assign num_out         = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed cases plus random traffic against a behavioural model.
module tb_data_sram_responder;
    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    // clock / reset
    always #5 clk = ~clk;

    data_sram_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .num_out         (num_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [31:0] mem_m [int];
    logic [15:0] sw_at [int];
    logic [15:0] led_m;
    logic [31:0] num_m, scratch_m, timer_base, rd_cnt_m, wr_cnt_m;
    int          timer_cyc, rst_cyc, cyc;
    logic [15:0] sw_drive;
    logic [31:0] last_rdata;
    logic        last_known;
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Timer value seen at edge number cyc: last loaded value plus elapsed edges.
    function automatic logic [31:0] m_timer();
        return timer_base + 32'(cyc - timer_cyc);
    endfunction

    function automatic logic [15:0] m_switch();
        if (cyc - 2 >= rst_cyc) return sw_at[cyc-2];
        return 16'h0000;
    endfunction

    function automatic logic [31:0] m_conf(input logic [15:0] off);
        case (off)
            16'h0000: return {16'h0000, led_m};
            16'h0004: return {16'h0000, m_switch()};
            16'h0008: return m_timer();
            16'h000C: return num_m;
            16'h0010: return 32'h0000_0001;
            16'h0014: return scratch_m;
`ifdef CONFREG_PERF_CNT_EN
            16'h0020: return rd_cnt_m;
            16'h0024: return wr_cnt_m;
`endif
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        led_m      = 16'hFFFF;
        num_m      = 0;
        scratch_m  = 0;
        timer_base = 0;
        timer_cyc  = cyc;
        rst_cyc    = cyc;
        rd_cnt_m   = 0;
        wr_cnt_m   = 0;
        last_rdata = 0;
        last_known = 1'b1;
        exp_q.delete();
    endtask

    // driver: one bus cycle, model update at the edge, checks #1 later
    task automatic bus_cycle(input logic en, input logic [3:0] we, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag);
        logic        conf, known, perf;
        int          idx;
        logic [15:0] off;
        logic [31:0] exp_v, t;
        data_sram_en    = en;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        switch_in       = sw_drive;
        @(posedge clk);
        sw_at[cyc] = sw_drive;
        conf  = (addr[31:16] == 16'hBFAF);
        idx   = int'(addr[AW+1:2]);
        off   = {addr[15:2], 2'b00};
        known = 1'b1;
        exp_v = 0;
        if (en) begin
            if (conf) exp_v = m_conf(off);
            else if (mem_m.exists(idx)) exp_v = mem_m[idx];
            else known = 1'b0;
            if (known) exp_q.push_back(exp_v);
            last_known = known;
            last_rdata = exp_v;
            perf = conf && (off == 16'h0020 || off == 16'h0024);
            if (!perf) begin
                if (we != 0) wr_cnt_m++;
                else         rd_cnt_m++;
            end
            if (we != 0) begin
                if (!conf) begin
                    if (mem_m.exists(idx)) mem_m[idx] = apply_be(mem_m[idx], wdata, we);
                    else if (we == 4'hF)   mem_m[idx] = wdata;
                end else begin
                    case (off)
                        16'h0000: begin
                            t = apply_be({16'h0, led_m}, wdata, we);
                            led_m = t[15:0];
                        end
                        16'h0008: begin
                            timer_base = apply_be(m_timer() + 32'd1, wdata, we);
                            timer_cyc  = cyc + 1;
                        end
                        16'h000C: num_m     = apply_be(num_m, wdata, we);
                        16'h0014: scratch_m = apply_be(scratch_m, wdata, we);
                        16'h0020: rd_cnt_m  = 0;
                        16'h0024: wr_cnt_m  = 0;
                        default: ;
                    endcase
                end
            end
        end
        cyc++;
        #1;
        if (en && known) check_eq(tag, data_sram_rdata, exp_q.pop_front());
        else if (!en && last_known) check_eq({tag, "_hold"}, data_sram_rdata, last_rdata);
        check_eq({tag, "_led"}, {16'h0, led_out}, {16'h0, led_m});
        check_eq({tag, "_num"}, num_out, num_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 4'h0, 32'h0, 32'h0, "idle");
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  w;
        int          k;
        logic [15:0] offs [10];
        offs = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h20, 16'h24, 16'h40};
        cyc = 0;
        sw_drive = 16'h0;
        resetn = 1'b0;
        data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
        switch_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdata", data_sram_rdata, 32'h0);
        check_eq("rst_led", {16'h0, led_out}, 32'h0000_FFFF);
        check_eq("rst_num", num_out, 32'h0);
        #1 resetn = 1'b1;
        model_reset();

        // preload a window of RAM words (first read-back of each is unknown)
        for (int i = 0; i < 32; i++) bus_cycle(1'b1, 4'hF, 32'h100 + 4*i, $urandom, "init");

        bus_cycle(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, "wr100");
        bus_cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0, "rd100");
        check_eq("rd100_lit", data_sram_rdata, 32'hDEAD_BEEF);
        bus_cycle(1'b1, 4'hF, 32'h0000_0104, 32'h1122_3344, "wr104");
        bus_cycle(1'b1, 4'b0101, 32'h0000_0104, 32'hAABB_CCDD, "be104");
        bus_cycle(1'b1, 4'h0, 32'h0000_0104, 32'h0, "rd104");
        check_eq("be_lit", data_sram_rdata, 32'h11BB_33DD);
        idle(1);
        bus_cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0, "b2b0");
        bus_cycle(1'b1, 4'h0, 32'h0000_0104, 32'h0, "b2b1");
        bus_cycle(1'b1, 4'h0, 32'h0000_0108, 32'h0, "b2b2");
        bus_cycle(1'b1, 4'hF, 32'h0000_0108, 32'h5A5A_0F0F, "rdfirst");
        bus_cycle(1'b1, 4'h0, 32'h0004_0108, 32'h0, "alias");

        bus_cycle(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_00A5, "led_wr");
        check_eq("led_lit", {16'h0, led_out}, 32'h0000_00A5);
        sw_drive = 16'h1234;
        idle(3);
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0004, 32'h0, "sw_rd");
        check_eq("sw_lit", data_sram_rdata, 32'h0000_1234);
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0010, 32'h0, "simflag");
        check_eq("simflag_lit", data_sram_rdata, 32'h0000_0001);
        bus_cycle(1'b1, 4'hF, 32'hBFAF_0040, 32'hFFFF_FFFF, "unmap_wr");
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0040, 32'h0, "unmap_rd");
        check_eq("unmap_lit", data_sram_rdata, 32'h0);
        bus_cycle(1'b1, 4'hF, 32'hBFAF_0010, 32'h1234_5678, "ro_wr");
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0010, 32'h0, "ro_rd");
        bus_cycle(1'b1, 4'b0110, 32'hBFAF_000C, 32'hCAFE_F00D, "num_wr");
        bus_cycle(1'b1, 4'b1001, 32'hBFAF_0014, 32'h8765_4321, "scr_wr");
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0014, 32'h0, "scr_rd");

        bus_cycle(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE, "tmr_wr");
        idle(2);
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, "tmr_wrap");
        check_eq("tmr_wrap_lit", data_sram_rdata, 32'h0);
        bus_cycle(1'b1, 4'b0100, 32'hBFAF_0008, 32'h00AB_0000, "tmr_part");
        idle(1);
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, "tmr_rd");

        // perf counters (unmapped when the feature is compiled out)
        bus_cycle(1'b1, 4'h1, 32'hBFAF_0020, 32'h0, "rdc_clr");
        bus_cycle(1'b1, 4'h8, 32'hBFAF_0024, 32'h0, "wrc_clr");
        bus_cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0, "pc_r0");
        bus_cycle(1'b1, 4'hF, 32'h0000_010C, 32'h0BAD_F00D, "pc_w0");
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0010, 32'h0, "pc_r1");
        bus_cycle(1'b1, 4'h3, 32'hBFAF_0014, 32'h1111_2222, "pc_w1");
        bus_cycle(1'b1, 4'h0, 32'h0000_0104, 32'h0, "pc_r2");
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0020, 32'h0, "rdc_rd");
`ifdef CONFREG_PERF_CNT_EN
        check_eq("rdc_lit", data_sram_rdata, 32'd3);
`else
        check_eq("rdc_off_lit", data_sram_rdata, 32'd0);
`endif
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0024, 32'h0, "wrc_rd");
`ifdef CONFREG_PERF_CNT_EN
        check_eq("wrc_lit", data_sram_rdata, 32'd2);
`else
        check_eq("wrc_off_lit", data_sram_rdata, 32'd0);
`endif
        bus_cycle(1'b1, 4'h2, 32'hBFAF_0020, 32'hFFFF_FFFF, "rdc_clr2");
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0020, 32'h0, "rdc_rd2");
        check_eq("rdc_clr_lit", data_sram_rdata, 32'd0);

        // random traffic over the preloaded RAM window and the config map
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) sw_drive = 16'($urandom);
            w = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(32'h40, 32'h5F);
                a = {14'($urandom), 16'(k), 2'($urandom)};
            end else begin
                a = {16'hBFAF, offs[$urandom_range(0, 9)]};
                a[1:0] = 2'($urandom);
            end
            bus_cycle(1'($urandom_range(0, 3) != 0), w, a, d, "rand");
        end

        // asynchronous reset in the middle of a run
        data_sram_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_eq("mrst_led", {16'h0, led_out}, 32'h0000_FFFF);
        check_eq("mrst_num", num_out, 32'h0);
        check_eq("mrst_rdata", data_sram_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, "mrst_tmr0");
        check_eq("mrst_tmr_lit", data_sram_rdata, 32'h0);
        idle(2);
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, "mrst_tmr3");
        bus_cycle(1'b1, 4'h0, 32'hBFAF_0014, 32'h0, "mrst_scr");
        bus_cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0, "mrst_ram");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
